// File: rtl/sram_ctrl.sv
// Single-port SRAM access sequencer: turns req/done word or byte transfers into registered
// active-low SRAM strobes with a configurable number of access (wait-state) cycles.
module sram_ctrl #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req,
  input  logic              rd_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        be,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ADDR,
  output logic              CE,
  output logic              UB,
  output logic              LB,
  output logic              OE,
  output logic              WE,
  output logic [DATA_W-1:0] Data_to_SRAM,
  output logic              drive_en,
  input  logic [DATA_W-1:0] Data_from_SRAM
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  localparam logic [3:0] CntLoad = 4'(WAIT_STATES - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       rd_q;

  // Every output is loaded on the edge that enters the state it belongs to, so the
  // strobes are plain flops with no path from req.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      rd_q         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rdata        <= '0;
      ADDR         <= '0;
      CE           <= 1'b1;
      UB           <= 1'b1;
      LB           <= 1'b1;
      OE           <= 1'b1;
      WE           <= 1'b1;
      Data_to_SRAM <= '0;
      drive_en     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            state_q      <= StSetup;
            rd_q         <= rd_wr;
            busy         <= 1'b1;
            ADDR         <= addr;
            CE           <= 1'b0;
            UB           <= ~be[1];
            LB           <= ~be[0];
            OE           <= ~rd_wr;
            WE           <= 1'b1;
            drive_en     <= ~rd_wr;
            Data_to_SRAM <= rd_wr ? '0 : wdata;
          end
        end
        StSetup: begin
          state_q <= StAccess;
          cnt_q   <= CntLoad;
          WE      <= rd_q;
        end
        StAccess: begin
          if (cnt_q == 4'd0) begin
            state_q <= StDone;
            done    <= 1'b1;
            OE      <= 1'b1;
            WE      <= 1'b1;
            // Write data stays driven through DONE to give one cycle of hold after WE.
            if (rd_q) begin
              rdata <= Data_from_SRAM;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          state_q      <= StIdle;
          busy         <= 1'b0;
          ADDR         <= '0;
          CE           <= 1'b1;
          UB           <= 1'b1;
          LB           <= 1'b1;
          OE           <= 1'b1;
          WE           <= 1'b1;
          drive_en     <= 1'b0;
          Data_to_SRAM <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed self-checking bench for sram_ctrl with a small behavioural SRAM model.
module tb_sram_ctrl;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;
  localparam int unsigned WS = 2;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          req = 1'b0;
  logic          rd_wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [1:0]    be = 2'b11;
  logic          busy, done, CE, UB, LB, OE, WE, drive_en;
  logic [DW-1:0] rdata, Data_to_SRAM, Data_from_SRAM;
  logic [AW-1:0] ADDR;

  logic [15:0] mem [256];

  int errors = 0;
  int checks = 0;

  sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .rd_wr(rd_wr), .addr(addr), .wdata(wdata), .be(be),
    .busy(busy), .done(done), .rdata(rdata), .ADDR(ADDR), .CE(CE), .UB(UB), .LB(LB), .OE(OE),
    .WE(WE), .Data_to_SRAM(Data_to_SRAM), .drive_en(drive_en), .Data_from_SRAM(Data_from_SRAM)
  );

  always #5 Clk = ~Clk;

  // SRAM model: byte-lane writes while CE and WE are low, reads only when OE is low.
  always @(posedge Clk) begin
    if (!CE && !WE) begin
      if (!UB) mem[ADDR[7:0]][15:8] <= Data_to_SRAM[15:8];
      if (!LB) mem[ADDR[7:0]][7:0]  <= Data_to_SRAM[7:0];
    end
  end
  assign Data_from_SRAM = (!CE && !OE) ? mem[ADDR[7:0]] : 16'hDEAD;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Returns in cycle 1 (SETUP) of the accepted transfer.
  task automatic start(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [1:0] b);
    rd_wr = rw; addr = a; wdata = d; be = b; req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0; req = 1'b1; rd_wr = 1'b1; addr = 20'h00055;
    tick();
    tick();
    checks++;
    if ({CE, UB, LB, OE, WE, busy, done, drive_en} !== 8'b11111000) begin
      errors++;
      $display("FAIL reset_strobes: got %b required 11111000",
               {CE, UB, LB, OE, WE, busy, done, drive_en});
    end
    checks++;
    if (rdata !== 16'h0000 || ADDR !== 20'h0 || Data_to_SRAM !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h ADDR=%h dout=%h required all zero",
               rdata, ADDR, Data_to_SRAM);
    end
    req = 1'b0; Reset = 1'b1;
    tick();
  endtask

  task automatic test_word_write;
    logic [5:0] exp [5];
    exp = '{6'b011110, 6'b001110, 6'b001110, 6'b011111, 6'b111000};
    start(1'b0, 20'h00123, 16'hBEEF, 2'b11);
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if ({CE, WE, OE, drive_en, busy, done} !== exp[c-1]) begin
        errors++;
        $display("FAIL write_strobes cyc%0d: CE/WE/OE/den/busy/done=%b required %b", c,
                 {CE, WE, OE, drive_en, busy, done}, exp[c-1]);
      end
      if (c == 2) begin
        checks++;
        if ({ADDR, UB, LB, Data_to_SRAM} !== {20'h00123, 2'b00, 16'hBEEF}) begin
          errors++;
          $display("FAIL write_bus: ADDR=%h UB=%b LB=%b dout=%h required 00123 0 0 beef",
                   ADDR, UB, LB, Data_to_SRAM);
        end
      end
      if (c < 5) tick();
    end
    checks++;
    if (mem[8'h23] !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_mem: got %h required beef", mem[8'h23]);
    end
  endtask

  task automatic test_word_read;
    logic [5:0] exp [5];
    exp = '{6'b010010, 6'b010010, 6'b010010, 6'b011011, 6'b111000};
    start(1'b1, 20'h00123, 16'h0000, 2'b11);
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if ({CE, WE, OE, drive_en, busy, done} !== exp[c-1]) begin
        errors++;
        $display("FAIL read_strobes cyc%0d: CE/WE/OE/den/busy/done=%b required %b", c,
                 {CE, WE, OE, drive_en, busy, done}, exp[c-1]);
      end
      if (c >= 4) begin
        checks++;
        if (rdata !== 16'hBEEF) begin
          errors++;
          $display("FAIL read_rdata cyc%0d: got %h required beef", c, rdata);
        end
      end
      if (c < 5) tick();
    end
  endtask

  task automatic test_byte_write;
    start(1'b0, 20'h00040, 16'h1234, 2'b11);
    wait_idle();
    start(1'b0, 20'h00040, 16'hAB00, 2'b10);
    checks++;
    if ({UB, LB} !== 2'b01) begin
      errors++;
      $display("FAIL byte_lanes: UB/LB=%b required 01", {UB, LB});
    end
    wait_idle();
    checks++;
    if (rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL rdata_held_write: got %h required beef", rdata);
    end
    start(1'b1, 20'h00040, 16'h0000, 2'b11);
    wait_idle();
    checks++;
    if (rdata !== 16'hAB34) begin
      errors++;
      $display("FAIL byte_readback: got %h required ab34", rdata);
    end
  endtask

  task automatic test_busy_ignore;
    int dones = 0;
    int ce_low = 0;
    start(1'b1, 20'h00123, 16'h0000, 2'b11);
    for (int c = 1; c <= 10; c++) begin
      if (done) dones++;
      if (!CE) ce_low++;
      if (c == 3) begin
        req = 1'b0;
        checks++;
        if (ADDR !== 20'h00123) begin
          errors++;
          $display("FAIL busy_addr: got %h required 00123", ADDR);
        end
      end
      if (c == 2) begin
        addr = 20'h00040; req = 1'b1;
      end
      tick();
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL busy_dones: got %0d required 1", dones);
    end
    checks++;
    if (ce_low !== 4) begin
      errors++;
      $display("FAIL busy_ce_cycles: got %0d required 4", ce_low);
    end
  endtask

  task automatic test_back_to_back;
    int starts [3];
    int ns = 0;
    logic prev = 1'b0;
    rd_wr = 1'b1; addr = 20'h00123; be = 2'b11; req = 1'b1;
    tick();
    for (int c = 1; c <= 12; c++) begin
      if (busy && !prev && ns < 3) begin
        starts[ns] = c;
        ns++;
      end
      prev = busy;
      tick();
    end
    req = 1'b0;
    checks++;
    if (ns !== 3 || starts[0] !== 1 || starts[1] - starts[0] !== 5 || starts[2] !== 11) begin
      errors++;
      $display("FAIL back_to_back: n=%0d starts=%0d,%0d,%0d required 3 at 1,6,11",
               ns, starts[0], starts[1], starts[2]);
    end
    wait_idle();
  endtask

  task automatic test_abort;
    int dones = 0;
    start(1'b1, 20'h00040, 16'h0000, 2'b11);
    tick();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    checks++;
    if ({CE, UB, LB, OE, WE, drive_en, busy, done} !== 8'b11111000) begin
      errors++;
      $display("FAIL abort_strobes: got %b required 11111000",
               {CE, UB, LB, OE, WE, drive_en, busy, done});
    end
    for (int c = 0; c < 6; c++) begin
      if (done) dones++;
      tick();
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_done: got %0d pulses required 0", dones);
    end
    checks++;
    if (rdata !== 16'h0000) begin
      errors++;
      $display("FAIL abort_rdata: got %h required 0000", rdata);
    end
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_word_read();
    test_byte_write();
    test_busy_ignore();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
